// File: rtl/deal_ctrl.sv
`timescale 1ns/1ps
// deal_ctrl: blackjack round controller. Deals two cards each to player and
// dealer, runs the player's hit/stand turn, then plays the dealer out to
// DEALER_STAND and resolves the round.
//
// Ports:
//   clk, reset        - system clock, asynchronous active-high reset
//   start             - level; starts a round from IDLE or DONE
//   hit, stand        - player actions, honoured only on the player's turn
//   card_value[3:0]   - current card from the RNG (1 = ace, 0 or >10 count as 10)
//   player_total[4:0] - player best total (registered)
//   dealer_total[4:0] - dealer best total (registered)
//   player_cards[3:0] - cards in player hand, saturating at 15
//   dealer_cards[3:0] - cards in dealer hand, saturating at 15
//   player_turn       - high while waiting for the player's action
//   done              - round finished; exactly one of win/lose/push is high
module deal_ctrl #(
  parameter int unsigned DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic [3:0] card_value,
  output logic [4:0] player_total,
  output logic [4:0] dealer_total,
  output logic [3:0] player_cards,
  output logic [3:0] dealer_cards,
  output logic       player_turn,
  output logic       done,
  output logic       win,
  output logic       lose,
  output logic       push
);

  typedef enum logic [3:0] {
    StIdle, StDealP1, StDealD1, StDealP2, StDealD2, StPlayerTurn,
    StPlayerDraw, StDealerTurn, StDealerDraw, StResolve, StDone
  } state_e;

  localparam logic [5:0] StandThr = 6'(DEALER_STAND);

  function automatic logic [5:0] card_pts(input logic [3:0] c);
    if (c == 4'd0 || c > 4'd10) card_pts = 6'd10;
    else                        card_pts = {2'b00, c};
  endfunction

  // One ace may count 11 as long as that does not bust the hand.
  function automatic logic [5:0] best_of(input logic [5:0] h, input logic a);
    best_of = (a && h <= 6'd11) ? h + 6'd10 : h;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] n);
    sat_inc = (n == 4'd15) ? n : n + 4'd1;
  endfunction

  state_e     state_q, state_d;
  logic [5:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
  logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
  logic [3:0] p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
  logic [4:0] p_tot_q, p_tot_d, d_tot_q, d_tot_d;
  logic       pturn_q, pturn_d, done_q, done_d;
  logic       win_q, win_d, lose_q, lose_d, push_q, push_d;

  logic [5:0] pts;
  logic       is_ace, p_take, d_take;
  logic [5:0] p_best, d_best, p_best_n;

  always_comb begin
    state_d  = state_q;
    p_hard_d = p_hard_q;
    p_ace_d  = p_ace_q;
    p_cnt_d  = p_cnt_q;
    d_hard_d = d_hard_q;
    d_ace_d  = d_ace_q;
    d_cnt_d  = d_cnt_q;
    win_d    = win_q;
    lose_d   = lose_q;
    push_d   = push_q;

    pts    = card_pts(card_value);
    is_ace = (card_value == 4'd1);
    p_best = best_of(p_hard_q, p_ace_q);
    d_best = best_of(d_hard_q, d_ace_q);

    // Each deal/draw state lasts one cycle, so the card is taken exactly once.
    p_take = (state_q == StDealP1) || (state_q == StDealP2) || (state_q == StPlayerDraw);
    d_take = (state_q == StDealD1) || (state_q == StDealD2) || (state_q == StDealerDraw);

    if (p_take) begin
      p_hard_d = p_hard_q + pts;
      p_ace_d  = p_ace_q | is_ace;
      p_cnt_d  = sat_inc(p_cnt_q);
    end
    if (d_take) begin
      d_hard_d = d_hard_q + pts;
      d_ace_d  = d_ace_q | is_ace;
      d_cnt_d  = sat_inc(d_cnt_q);
    end
    p_best_n = best_of(p_hard_d, p_ace_d);

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StDealP1;
          p_hard_d = '0;
          p_ace_d  = 1'b0;
          p_cnt_d  = '0;
          d_hard_d = '0;
          d_ace_d  = 1'b0;
          d_cnt_d  = '0;
          win_d    = 1'b0;
          lose_d   = 1'b0;
          push_d   = 1'b0;
        end
      end
      StDealP1: state_d = StDealD1;
      StDealD1: state_d = StDealP2;
      StDealP2: state_d = StDealD2;
      StDealD2: state_d = StPlayerTurn;
      StPlayerTurn: begin
        // A natural 21 stands automatically; stand beats a simultaneous hit.
        if (p_best == 6'd21 || stand) state_d = StDealerTurn;
        else if (hit)                 state_d = StPlayerDraw;
      end
      StPlayerDraw: begin
        if (p_hard_d > 6'd21)       state_d = StResolve;
        else if (p_best_n == 6'd21) state_d = StDealerTurn;
        else                        state_d = StPlayerTurn;
      end
      StDealerTurn: state_d = (d_best < StandThr) ? StDealerDraw : StResolve;
      StDealerDraw: state_d = StDealerTurn;
      StResolve: begin
        state_d = StDone;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        push_d  = 1'b0;
        if (p_hard_q > 6'd21)      lose_d = 1'b1;
        else if (d_hard_q > 6'd21) win_d  = 1'b1;
        else if (p_best > d_best)  win_d  = 1'b1;
        else if (p_best < d_best)  lose_d = 1'b1;
        else                       push_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Totals reflect the hand as it will be after this edge.
    p_tot_d = 5'(best_of(p_hard_d, p_ace_d));
    d_tot_d = 5'(best_of(d_hard_d, d_ace_d));
    pturn_d = (state_d == StPlayerTurn);
    done_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      p_hard_q <= '0;
      p_ace_q  <= 1'b0;
      p_cnt_q  <= '0;
      d_hard_q <= '0;
      d_ace_q  <= 1'b0;
      d_cnt_q  <= '0;
      p_tot_q  <= '0;
      d_tot_q  <= '0;
      pturn_q  <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_hard_q <= p_hard_d;
      p_ace_q  <= p_ace_d;
      p_cnt_q  <= p_cnt_d;
      d_hard_q <= d_hard_d;
      d_ace_q  <= d_ace_d;
      d_cnt_q  <= d_cnt_d;
      p_tot_q  <= p_tot_d;
      d_tot_q  <= d_tot_d;
      pturn_q  <= pturn_d;
      done_q   <= done_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      push_q   <= push_d;
    end
  end

  assign player_total = p_tot_q;
  assign dealer_total = d_tot_q;
  assign player_cards = p_cnt_q;
  assign dealer_cards = d_cnt_q;
  assign player_turn  = pturn_q;
  assign done         = done_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign push         = push_q;

endmodule

// File: tb/tb_deal_ctrl.sv
`timescale 1ns/1ps
// Bench for deal_ctrl: directed round scenarios plus randomized rounds scored
// against a round-level blackjack model.
module tb_deal_ctrl;

  localparam int Stand = 17;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic [4:0] player_total, dealer_total;
  logic [3:0] player_cards, dealer_cards;
  logic       player_turn, done, win, lose, push;

  int vec_cnt = 0;
  int miss_cnt = 0;

  int deck[$];
  int acts[$];
  int exp_pt, exp_dt, exp_pc, exp_dc;
  bit exp_w, exp_l, exp_p;

  deal_ctrl #(.DEALER_STAND(Stand)) dut (
    .clk(clk), .reset(reset), .start(start), .hit(hit), .stand(stand),
    .card_value(card_value), .player_total(player_total), .dealer_total(dealer_total),
    .player_cards(player_cards), .dealer_cards(dealer_cards), .player_turn(player_turn),
    .done(done), .win(win), .lose(lose), .push(push)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cval(int c);
    return (c == 0 || c > 10) ? 10 : c;
  endfunction

  function automatic int best(int h, bit a);
    return (a && h <= 11) ? h + 10 : h;
  endfunction

  function automatic int pop_card();
    if (deck.size() > 0) return deck.pop_front();
    return int'($urandom_range(1, 10));
  endfunction

  // Plays one full round from IDLE/DONE using deck/acts; fills exp_* from
  // blackjack rules with the documented one-cycle-per-step timing.
  task automatic run_round();
    int ph, dh, pc, dc, c, a, pb, db;
    bit pa, da, pbust;
    ph = 0; dh = 0; pc = 0; dc = 0; pa = 0; da = 0; pbust = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) begin
      c = pop_card(); card_value = 4'(c); tick();
      if (i % 2 == 0) begin ph += cval(c); pa |= (c == 1); pc++; end
      else begin dh += cval(c); da |= (c == 1); dc++; end
    end
    if (best(ph, pa) == 21) tick();
    else begin
      for (int k = 0; k < 16; k++) begin
        a = (acts.size() > 0) ? acts.pop_front() : 0;
        if (a == 1) begin
          c = pop_card(); card_value = 4'(c); hit = 1; tick(); hit = 0; tick();
          ph += cval(c); pa |= (c == 1); pc++;
          if (ph > 21) begin pbust = 1; break; end
          if (best(ph, pa) == 21) break;
        end else begin
          stand = 1; tick(); stand = 0;
          break;
        end
      end
    end
    if (pbust) tick();
    else begin
      while (best(dh, da) < Stand) begin
        tick(); c = pop_card(); card_value = 4'(c); tick();
        dh += cval(c); da |= (c == 1); dc++;
      end
      tick(); tick();
    end
    pb = best(ph, pa); db = best(dh, da);
    exp_pt = pb; exp_dt = db;
    exp_pc = (pc > 15) ? 15 : pc; exp_dc = (dc > 15) ? 15 : dc;
    exp_l = pbust || (dh <= 21 && pb < db);
    exp_w = !pbust && (dh > 21 || pb > db);
    exp_p = !pbust && dh <= 21 && pb == db;
  endtask

  task automatic deal4(input int c0, input int c1, input int c2, input int c3);
    int cs[4];
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 4; i++) begin card_value = 4'(cs[i]); tick(); end
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    vec_cnt++;
    if ({player_total, dealer_total, player_cards, dealer_cards, player_turn, done, win, lose,
         push} !== 23'd0) begin
      miss_cnt++; $display("FAIL reset_outputs: got %h, need 0", {player_total, dealer_total,
        player_cards, dealer_cards, player_turn, done, win, lose, push});
    end
    reset = 0; hit = 1; stand = 1; card_value = 4'd7;
    tick(); tick(); tick();
    hit = 0; stand = 0;
    vec_cnt++;
    if ({player_cards, dealer_cards, player_turn, done} !== 10'd0) begin
      miss_cnt++; $display("FAIL idle_no_start: cards %0d/%0d turn %0b done %0b, need all 0",
        player_cards, dealer_cards, player_turn, done);
    end
  endtask

  task automatic test_stand_lose();
    deck = '{10, 9, 7, 10}; acts = '{0};
    run_round();
    vec_cnt++;
    if ({player_total, dealer_total} !== {5'd17, 5'd19}) begin
      miss_cnt++; $display("FAIL stand_lose_totals: got %0d/%0d, need 17/19",
        player_total, dealer_total);
    end
    vec_cnt++;
    if ({done, win, lose, push} !== 4'b1010) begin
      miss_cnt++; $display("FAIL stand_lose_flags: got %b, need 1010", {done, win, lose, push});
    end
  endtask

  task automatic test_blackjack_push();
    deck = '{1, 10, 10, 6, 5}; acts.delete();
    run_round();
    vec_cnt++;
    if ({player_total, dealer_total, dealer_cards} !== {5'd21, 5'd21, 4'd3}) begin
      miss_cnt++; $display("FAIL bj_push_totals: got %0d/%0d dc %0d, need 21/21 dc 3",
        player_total, dealer_total, dealer_cards);
    end
    vec_cnt++;
    if ({done, win, lose, push} !== 4'b1001) begin
      miss_cnt++; $display("FAIL bj_push_flags: got %b, need 1001", {done, win, lose, push});
    end
  endtask

  task automatic test_bust();
    deck = '{10, 7, 6, 9, 10}; acts = '{1};
    run_round();
    vec_cnt++;
    if ({player_total, player_cards, dealer_cards} !== {5'd26, 4'd3, 4'd2}) begin
      miss_cnt++; $display("FAIL bust_hand: got pt %0d pc %0d dc %0d, need 26 3 2",
        player_total, player_cards, dealer_cards);
    end
    vec_cnt++;
    if ({done, win, lose, push} !== 4'b1010) begin
      miss_cnt++; $display("FAIL bust_flags: got %b, need 1010", {done, win, lose, push});
    end
  endtask

  task automatic test_soft17();
    deck = '{10, 1, 8, 6}; acts = '{0};
    run_round();
    vec_cnt++;
    if ({player_total, dealer_total, dealer_cards} !== {5'd18, 5'd17, 4'd2}) begin
      miss_cnt++; $display("FAIL soft17_hand: got %0d/%0d dc %0d, need 18/17 dc 2",
        player_total, dealer_total, dealer_cards);
    end
    vec_cnt++;
    if ({done, win, lose, push} !== 4'b1100) begin
      miss_cnt++; $display("FAIL soft17_flags: got %b, need 1100", {done, win, lose, push});
    end
  endtask

  task automatic test_hit_stand_same();
    deal4(10, 10, 5, 7);
    vec_cnt++;
    if (player_turn !== 1'b1) begin
      miss_cnt++; $display("FAIL turn_after_deal: got %b, need 1", player_turn);
    end
    hit = 1; stand = 1; card_value = 4'd5; tick(); hit = 0; stand = 0;
    vec_cnt++;
    if (player_turn !== 1'b0) begin
      miss_cnt++; $display("FAIL hs_turn_left: got %b, need 0", player_turn);
    end
    tick(); tick();
    vec_cnt++;
    if ({player_cards, player_total, done, lose} !== {4'd2, 5'd15, 1'b1, 1'b1}) begin
      miss_cnt++; $display("FAIL hs_no_draw: pc %0d pt %0d done %b lose %b, need 2 15 1 1",
        player_cards, player_total, done, lose);
    end
    // Reset while the dealer is mid-draw.
    deal4(10, 2, 5, 3);
    stand = 1; tick(); stand = 0;
    tick();
    reset = 1; #1;
    vec_cnt++;
    if ({player_total, dealer_total, player_cards, dealer_cards, player_turn, done, win, lose,
         push} !== 23'd0) begin
      miss_cnt++; $display("FAIL reset_mid_draw: got pt %0d dt %0d pc %0d dc %0d, need 0",
        player_total, dealer_total, player_cards, dealer_cards);
    end
    tick(); reset = 0; tick(); tick();
    vec_cnt++;
    if ({player_cards, dealer_cards, done} !== 9'd0) begin
      miss_cnt++; $display("FAIL post_reset_idle: pc %0d dc %0d done %b, need 0",
        player_cards, dealer_cards, done);
    end
  endtask

  task automatic test_start_ignored();
    deal4(10, 7, 6, 9);
    start = 1; tick(); tick(); start = 0;
    vec_cnt++;
    if ({player_turn, player_cards, dealer_cards} !== {1'b1, 4'd2, 4'd2}) begin
      miss_cnt++; $display("FAIL start_in_turn: turn %b pc %0d dc %0d, need 1 2 2",
        player_turn, player_cards, dealer_cards);
    end
    stand = 1; tick(); stand = 0;
    tick(); card_value = 4'd2; tick(); tick(); tick();
    vec_cnt++;
    if ({dealer_total, dealer_cards, done, lose} !== {5'd18, 4'd3, 1'b1, 1'b1}) begin
      miss_cnt++; $display("FAIL dealer_draw: dt %0d dc %0d done %b lose %b, need 18 3 1 1",
        dealer_total, dealer_cards, done, lose);
    end
    start = 1; tick();
    vec_cnt++;
    if ({player_total, dealer_total, player_cards, dealer_cards, done, win, lose, push}
        !== 22'd0) begin
      miss_cnt++; $display("FAIL restart_clear: pt %0d dt %0d pc %0d dc %0d flags %b, need 0",
        player_total, dealer_total, player_cards, dealer_cards, {done, win, lose, push});
    end
    card_value = 4'd3; tick(); start = 0;
    vec_cnt++;
    if ({player_cards, player_total} !== {4'd1, 5'd3}) begin
      miss_cnt++; $display("FAIL restart_p1: pc %0d pt %0d, need 1 3", player_cards, player_total);
    end
    reset = 1; tick(); reset = 0; tick();
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 40; r++) begin
      deck.delete(); acts.delete();
      for (int i = 0; i < 14; i++) begin
        c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 10));
        deck.push_back(c);
      end
      for (int i = 0; i < 4; i++) acts.push_back(int'($urandom_range(0, 1)));
      run_round();
      vec_cnt++;
      if ({player_total, dealer_total} !== {5'(exp_pt), 5'(exp_dt)}) begin
        miss_cnt++; $display("FAIL rnd%0d_totals: got %0d/%0d, need %0d/%0d", r,
          player_total, dealer_total, exp_pt, exp_dt);
      end
      vec_cnt++;
      if ({player_cards, dealer_cards} !== {4'(exp_pc), 4'(exp_dc)}) begin
        miss_cnt++; $display("FAIL rnd%0d_cards: got %0d/%0d, need %0d/%0d", r,
          player_cards, dealer_cards, exp_pc, exp_dc);
      end
      vec_cnt++;
      if ({done, win, lose, push} !== {1'b1, exp_w, exp_l, exp_p}) begin
        miss_cnt++; $display("FAIL rnd%0d_flags: got %b, need %b", r,
          {done, win, lose, push}, {1'b1, exp_w, exp_l, exp_p});
      end
    end
  endtask

  initial begin
    test_reset();
    test_stand_lose();
    test_blackjack_push();
    test_bust();
    test_soft17();
    test_hit_stand_same();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/deal_ctrl.md
DEAL_CTRL -- requirements
Module: deal_ctrl

Interface
REQ-001 SHALL have parameter DEALER_STAND, default 17, meaning the dealer best total at or above which the dealer stops drawing.
REQ-002 SHALL have port clk, input, 1, single system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, level; begins a new round when sampled high in IDLE or DONE.
REQ-005 SHALL have port hit, input, 1, player requests one card; single-cycle pulse.
REQ-006 SHALL have port stand, input, 1, player ends turn; single-cycle pulse.
REQ-007 SHALL have port card_value, input, 4, card from the free-running card RNG; legal range 1..10, where 1 is an ace.
REQ-008 SHALL have port player_total, output, 5, player best total.
REQ-009 SHALL have port dealer_total, output, 5, dealer best total.
REQ-010 SHALL have port player_cards and dealer_cards, output, 4 each, cards held; each saturates at 15.
REQ-011 SHALL have ports player_turn, done, win, lose and push, output, 1 each, status flags, all registered.

Function
REQ-012 SHALL implement the states IDLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, PLAYER_TURN, PLAYER_DRAW, DEALER_TURN, DEALER_DRAW, RESOLVE and DONE.
REQ-013 SHALL, in each DEAL_* and *_DRAW state, sample card_value exactly once, on that state's single cycle, into the named hand.
REQ-014 SHALL keep, per hand, a hard sum (ace counts 1, 6 bits internal) and an ace flag.
REQ-015 SHALL compute best total as hard+10 if the ace flag is set and hard<=11, otherwise hard; it SHALL be output registered in the cycle after the sample.
REQ-016 SHALL treat a card_value of 0 as 10 and a card_value greater than 10 as 10.
REQ-017 SHALL, on start in IDLE or DONE, clear both hands, all result flags and done, then enter DEAL_P1.
REQ-018 SHALL ignore start in all other states.
REQ-019 SHALL sequence the deal DEAL_P1->DEAL_D1->DEAL_P2->DEAL_D2, one cycle each, then go to PLAYER_TURN.
REQ-020 SHALL hold player_turn=1 only in PLAYER_TURN.
REQ-021 SHALL, in PLAYER_TURN, go to PLAYER_DRAW on hit, or to DEALER_TURN on stand.
REQ-022 SHALL let stand win when hit and stand are both high in the same cycle.
REQ-023 SHALL ignore hit and stand outside PLAYER_TURN.
REQ-024 SHALL, on entering PLAYER_TURN with player best==21, go directly to DEALER_TURN next cycle without waiting for input.
REQ-025 SHALL, after PLAYER_DRAW, go to RESOLVE if player hard>21, to DEALER_TURN if player best==21, else back to PLAYER_TURN.
REQ-026 SHALL, in DEALER_TURN, go to DEALER_DRAW if dealer best<DEALER_STAND (soft 17 stands), else to RESOLVE.
REQ-027 SHALL return from DEALER_DRAW to DEALER_TURN.
REQ-028 SHALL decide in RESOLVE: player bust->lose; else dealer bust->win; else larger best total wins; equal->push.
REQ-029 SHALL set exactly one of win, lose or push and set done on entering DONE.
REQ-030 SHALL hold the result flags and totals in DONE until the next start.

Reset
REQ-031 SHALL, on reset high at any time including mid-round, immediately force state IDLE, all totals, counts and flags to 0, and player_turn=0.
REQ-032 SHALL, after reset deasserts, take no action until start is sampled high.

Verification
REQ-033 SHALL cover: cards 10,9,7,10 dealt, then stand -> player 17, dealer 19, lose=1, done=1.
REQ-034 SHALL cover: cards 1,10,10,6 -> player 21 auto-stand; dealer draws 5 -> dealer 21, push=1.
REQ-035 SHALL cover: player 10+6, hit draws 10 -> hard 26, lose=1; dealer_cards stays 2.
REQ-036 SHALL cover: dealer 1+6 -> soft 17, no draw; player 18 on stand -> win=1.
REQ-037 SHALL cover: hit and stand in the same cycle -> no card drawn, DEALER_TURN next; reset during DEALER_DRAW -> all outputs 0 next cycle.
REQ-038 SHALL cover: start held during PLAYER_TURN -> ignored; start in DONE -> counts cleared and DEAL_P1 entered.
